// File: rtl/ysyx_23060096_ifu_if.sv
// Instruction-fetch bus bundle: imem request/response plus the fetch-to-decode handshake.
// Latency: none, this is wiring only.
// Backpressure: imem_req_ready stalls requests; id_ready holds the decode slot.
//
// master : IFU side (drives the imem request and the decode slot)
// slave  : memory/decode side (drives ready, response and id_ready)
interface ysyx_23060096_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  modport master (
    output imem_req_valid, imem_addr, id_valid, id_pc, id_inst,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, id_valid, id_pc, id_inst,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );
endinterface

// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: REQ -> WAIT -> OUT loop, one instruction in flight, redirectable.
// Latency: 3 cycles per instruction with zero-wait memory and decode.
// Backpressure: waits on imem_req_ready / imem_rsp_valid; holds id_* stable until id_ready.
//
// Ports: clk, rst_n (synchronous, active-low); bus (ysyx_23060096_ifu_if.master);
//        redirect_valid/redirect_pc (jump/branch/trap target); fetch_cnt (instructions
//        accepted by decode); misalign_err (sticky misaligned-redirect flag).
// Optional feature: define YSYX_23060096_IFU_MISALIGN_CHK_EN to halt on a misaligned
//        redirect target; otherwise target bits [1:0] are cleared and misalign_err is 0.
module ysyx_23060096_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ysyx_23060096_ifu_if.master        bus,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic [31:0]                fetch_cnt,
  output logic                       misalign_err
);

`ifdef YSYX_23060096_IFU_MISALIGN_CHK_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] id_pc_q, id_inst_q;
  logic        cap;
  logic        cnt_inc;
  logic [31:0] redir_tgt;
  logic        redir_bad;

`ifdef YSYX_23060096_IFU_MISALIGN_CHK_EN
  logic err_q;
  assign redir_tgt    = redirect_pc;
  assign redir_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign misalign_err = err_q;
`else
  // Low target bits are simply discarded in this build.
  logic redir_lsb_unused;
  assign redir_lsb_unused = ^redirect_pc[1:0];
  assign redir_tgt    = {redirect_pc[31:2], 2'b00};
  assign redir_bad    = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign bus.imem_addr = pc_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_inst   = id_inst_q;

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    drop_d             = drop_q;
    cap                = 1'b0;
    cnt_inc            = 1'b0;
    bus.imem_req_valid = 1'b0;
    bus.id_valid       = 1'b0;
    case (state_q)
      S_REQ: begin
        // A redirect suppresses the request so the old PC is never fetched.
        bus.imem_req_valid = rst_n && !redirect_valid;
        if (redirect_valid) begin
          pc_d = redir_tgt;
        end else if (bus.imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redir_tgt;
          if (bus.imem_rsp_valid) begin
            // Response for the old path lands this very cycle: drop it right here.
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            // Still waiting: remember to throw the stale word away when it arrives.
            drop_d = 1'b1;
          end
        end else if (bus.imem_rsp_valid) begin
          drop_d  = 1'b0;
          state_d = S_REQ;
          if (!drop_q) begin
            cap     = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        bus.id_valid = 1'b1;
        // The handshake still counts if a redirect shows up in the same cycle.
        if (bus.id_ready) begin
          cnt_inc = 1'b1;
          state_d = S_REQ;
        end
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = S_REQ;
        end
      end
`ifdef YSYX_23060096_IFU_MISALIGN_CHK_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: begin
        state_d = S_REQ;
      end
    endcase
`ifdef YSYX_23060096_IFU_MISALIGN_CHK_EN
    if (redir_bad && (state_q != S_HALT)) begin
      state_d = S_HALT;
      drop_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      id_pc_q   <= 32'd0;
      id_inst_q <= 32'd0;
      fetch_cnt <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      if (cap) begin
        id_pc_q   <= pc_q;
        id_inst_q <= bus.imem_rsp_data;
      end
      if (cnt_inc) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

`ifdef YSYX_23060096_IFU_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (redir_bad) begin
      err_q <= 1'b1;
    end
  end
`endif

endmodule
